// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
//  - ARB_IDLE / ARB_GRANTED : arbiter FSM state encoding
//  - DEF_* localparams      : default bus geometry and watchdog length
//  - onehot_to_index        : converts a one-hot grant (up to 8 masters) to a master index
package wb_arb_pkg;

   localparam logic [0:0] ARB_IDLE    = 1'b0;
   localparam logic [0:0] ARB_GRANTED = 1'b1;

   localparam int DEF_NUM_MASTERS    = 2;
   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   // Callers zero-extend their grant vector to 8 bits; an all-zero input maps to index 0,
   // which is harmless because every use of the index is qualified by the GRANTED state.
   function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//  req  : per-master request vector
//  last : one-hot marker of the most recent winner (search starts just above it)
//  gnt  : one-hot winner, all zero when nothing is requested
module rr_priority_picker #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last,
   output logic [N-1:0] gnt
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] base;
   logic [2*N-1:0] dbl_gnt;

   // Requests are duplicated so the search can run off the top of the lower copy and wrap
   // into the upper copy. Subtracting the base (one above the last winner) clears the lowest
   // request at or above it; ANDing with the inverted difference isolates exactly that bit.
   // Folding both halves together turns the position back into a master number.
   assign dbl_req = {req, req};
   assign base    = {{N{1'b0}}, last} << 1;
   assign dbl_gnt = dbl_req & ~(dbl_req - base);
   assign gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_MASTERS masters.
// A winner keeps the bus for its whole cyc; a watchdog aborts a strobe the slave never acks.
//  clk, reset_n        : clock, asynchronous active-low reset
//  i_m_cyc/stb/we      : per-master control, one bit per master
//  i_m_addr/i_m_data   : packed per-master address and write data
//  o_m_ack/o_m_err     : ack and timeout error, routed to the granted master only
//  o_m_data            : slave read data, broadcast to all masters
//  o_s_*               : slave-side bus, driven by the granted master
//  i_s_ack/i_s_data    : slave ack and read data
//  o_grant             : registered one-hot grant, zero when idle
//  o_busy              : high while a master owns the bus
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_MASTERS-1:0]        i_m_cyc,
   input  logic [NUM_MASTERS-1:0]        i_m_stb,
   input  logic [NUM_MASTERS-1:0]        i_m_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] i_m_data,
   output logic [NUM_MASTERS-1:0]        o_m_ack,
   output logic [NUM_MASTERS-1:0]        o_m_err,
   output logic [DATA_W-1:0]             o_m_data,
   output logic                          o_s_cyc,
   output logic                          o_s_stb,
   output logic                          o_s_we,
   output logic [ADDR_W-1:0]             o_s_addr,
   output logic [DATA_W-1:0]             o_s_data,
   input  logic                          i_s_ack,
   input  logic [DATA_W-1:0]             i_s_data,
   output logic [NUM_MASTERS-1:0]        o_grant,
   output logic                          o_busy
);

   // A zero TIMEOUT_CYCLES disables the watchdog; the counter then shrinks to one idle bit.
   localparam bit            WDOG_EN = (TIMEOUT_CYCLES > 0);
   localparam int            CW      = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT   = CW'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CMAX    = '1;

   logic [0:0]             state;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [NUM_MASTERS-1:0] pointer_q;
   logic [CW-1:0]          count_q;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] pick;
   logic [2:0]             g_idx;
   logic                   granted;
   logic                   sel_cyc;
   logic                   sel_stb;
   logic                   sel_we;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_data;
   logic                   timeout_hit;
   logic                   leaving;

   assign req     = i_m_cyc & i_m_stb;
   assign granted = (state == ARB_GRANTED);

   rr_priority_picker #(
      .N(NUM_MASTERS)
   ) u_picker (
      .req (req),
      .last(pointer_q),
      .gnt (pick)
   );

   // Select the owning master's bus signals; the result is only used while GRANTED.
   always_comb begin
      g_idx    = onehot_to_index(8'(grant_q));
      sel_cyc  = 1'b0;
      sel_stb  = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (k == int'(g_idx)) begin
            sel_cyc  = i_m_cyc[k];
            sel_stb  = i_m_stb[k];
            sel_we   = i_m_we[k];
            sel_addr = i_m_addr[k*ADDR_W +: ADDR_W];
            sel_data = i_m_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // A timeout fires on the last allowed unacknowledged strobe; an ack in the same cycle wins.
   assign timeout_hit = WDOG_EN && granted && sel_stb && !i_s_ack && (count_q == LIMIT);
   assign leaving     = granted && (!sel_cyc || timeout_hit);

   // Bus outputs are gated by the state so an async reset silences the slave immediately.
   assign o_s_cyc  = granted && sel_cyc && !timeout_hit;
   assign o_s_stb  = granted && sel_stb && !timeout_hit;
   assign o_s_we   = granted && sel_we;
   assign o_s_addr = granted ? sel_addr : '0;
   assign o_s_data = granted ? sel_data : '0;
   assign o_m_ack  = granted ? (grant_q & {NUM_MASTERS{i_s_ack}}) : '0;
   assign o_m_err  = timeout_hit ? grant_q : '0;
   assign o_m_data = i_s_data;
   assign o_grant  = grant_q;
   assign o_busy   = granted;

   // Arbitration FSM: IDLE picks the next requester after the pointer; GRANTED holds the
   // owner until it drops cyc or the watchdog aborts. The pointer reset value places
   // master 0 first in line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         grant_q   <= '0;
         pointer_q <= {1'b1, {(NUM_MASTERS-1){1'b0}}};
      end else if (state == ARB_IDLE) begin
         if (|req) begin
            state     <= ARB_GRANTED;
            grant_q   <= pick;
            pointer_q <= pick;
         end
      end else begin
         if (leaving) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
         end
      end
   end

   // Watchdog counts unacknowledged strobe cycles of the current owner and saturates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (!granted || leaving || i_s_ack) begin
         count_q <= '0;
      end else if (sel_stb && (count_q != CMAX)) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (two masters, 8-cycle watchdog).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
module tb_wb_rr_arbiter;

   logic        clk;
   logic        reset_n;
   logic [1:0]  m_cyc;
   logic [1:0]  m_stb;
   logic [1:0]  m_we;
   logic [63:0] m_addr;
   logic [63:0] m_data;
   logic [1:0]  m_ack;
   logic [1:0]  m_err;
   logic [31:0] m_rdata;
   logic        s_cyc;
   logic        s_stb;
   logic        s_we;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic        s_ack;
   logic [31:0] s_rdata;
   logic [1:0]  grant;
   logic        busy;

   int passed = 0;
   int total  = 0;

   wb_rr_arbiter #(
      .NUM_MASTERS   (2),
      .ADDR_W        (32),
      .DATA_W        (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_m_cyc (m_cyc),
      .i_m_stb (m_stb),
      .i_m_we  (m_we),
      .i_m_addr(m_addr),
      .i_m_data(m_data),
      .o_m_ack (m_ack),
      .o_m_err (m_err),
      .o_m_data(m_rdata),
      .o_s_cyc (s_cyc),
      .o_s_stb (s_stb),
      .o_s_we  (s_we),
      .o_s_addr(s_addr),
      .o_s_data(s_wdata),
      .i_s_ack (s_ack),
      .i_s_data(s_rdata),
      .o_grant (grant),
      .o_busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      #2;
      total++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (s_cyc !== 1'b0) $display("FAIL reset_scyc: got %b want 0", s_cyc); else passed++;
      total++; if ({m_ack, m_err} !== 4'b0000) $display("FAIL reset_ackerr: got %b want 0000", {m_ack, m_err}); else passed++;
      tick();
      reset_n = 1'b1;
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      total++; if (grant !== 2'b01) $display("FAIL pre_reset_grant: got %b want 01", grant); else passed++;
      total++; if (s_cyc !== 1'b1) $display("FAIL pre_reset_scyc: got %b want 1", s_cyc); else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (grant !== 2'b00) $display("FAIL async_reset_grant: got %b want 00", grant); else passed++;
      total++; if (s_cyc !== 1'b0) $display("FAIL async_reset_scyc: got %b want 0", s_cyc); else passed++;
      m_cyc = 2'b11; m_stb = 2'b11;
      #1;
      reset_n = 1'b1;
      tick();
      total++; if (grant !== 2'b01) $display("FAIL post_reset_first: got %b want 01", grant); else passed++;
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      $display("[TB] test_round_robin");
      // Fresh reset so master 0 is first in line again.
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         total++; if (grant !== exp_g) $display("FAIL rr_grant_%0d: got %b want %b", i, grant, exp_g); else passed++;
         s_ack = 1'b1;
         #1;
         total++; if (m_ack !== exp_g) $display("FAIL rr_ack_%0d: got %b want %b", i, m_ack, exp_g); else passed++;
         tick();
         s_ack = 1'b0;
         m_cyc = m_cyc & ~exp_g;
         m_stb = m_stb & ~exp_g;
         #1;
         total++; if (s_cyc !== 1'b0) $display("FAIL rr_drop_scyc_%0d: got %b want 0", i, s_cyc); else passed++;
         tick();
         total++; if (grant !== 2'b00) $display("FAIL rr_idle_%0d: got %b want 00", i, grant); else passed++;
         if (i < 3) begin
            m_cyc = 2'b11; m_stb = 2'b11;
         end
      end
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
   endtask

   task automatic test_burst_hold();
      $display("[TB] test_burst_hold");
      m_cyc = 2'b10; m_stb = 2'b10;
      tick();
      total++; if (grant !== 2'b10) $display("FAIL burst_first: got %b want 10", grant); else passed++;
      m_cyc = 2'b11; m_stb = 2'b11;
      for (int b = 0; b < 4; b++) begin
         s_ack = 1'b1;
         #1;
         total++; if (grant !== 2'b10) $display("FAIL burst_hold_%0d: got %b want 10", b, grant); else passed++;
         total++; if (m_ack !== 2'b10) $display("FAIL burst_ack_%0d: got %b want 10", b, m_ack); else passed++;
         tick();
      end
      s_ack = 1'b0;
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      total++; if (grant !== 2'b00) $display("FAIL burst_gap: got %b want 00", grant); else passed++;
      tick();
      total++; if (grant !== 2'b01) $display("FAIL burst_next_owner: got %b want 01", grant); else passed++;
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
   endtask

   task automatic test_write_mux();
      $display("[TB] test_write_mux");
      m_addr = {32'h1111_2222, 32'h3000_0004};
      m_data = {32'h5A5A_5A5A, 32'h0000_00A5};
      s_rdata = 32'hDEAD_BEEF;
      m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
      tick();
      total++; if (s_addr !== 32'h3000_0004) $display("FAIL wr_addr: got %h want 30000004", s_addr); else passed++;
      total++; if (s_wdata !== 32'h0000_00A5) $display("FAIL wr_data: got %h want 000000a5", s_wdata); else passed++;
      total++; if (s_we !== 1'b1) $display("FAIL wr_we: got %b want 1", s_we); else passed++;
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== 2'b01) $display("FAIL wr_ack: got %b want 01", m_ack); else passed++;
      total++; if (m_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_broadcast: got %h want deadbeef", m_rdata); else passed++;
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
      tick();
      // A stray slave ack while idle must not reach any master.
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== 2'b00) $display("FAIL idle_ack_blocked: got %b want 00", m_ack); else passed++;
      s_ack = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      $display("[TB] test_timeout");
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      for (int c = 1; c < 8; c++) begin
         total++; if (m_err !== 2'b00) $display("FAIL to_early_err_%0d: got %b want 00", c, m_err); else passed++;
         tick();
      end
      total++; if (m_err !== 2'b01) $display("FAIL to_err: got %b want 01", m_err); else passed++;
      total++; if ({s_cyc, s_stb} !== 2'b00) $display("FAIL to_bus_cut: got %b want 00", {s_cyc, s_stb}); else passed++;
      tick();
      m_cyc = 2'b00; m_stb = 2'b00;
      total++; if ({grant, busy} !== 3'b000) $display("FAIL to_idle: got %b want 000", {grant, busy}); else passed++;
      tick();
   endtask

   task automatic test_ack_vs_timeout();
      $display("[TB] test_ack_vs_timeout");
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      for (int c = 1; c < 8; c++) tick();
      s_ack = 1'b1;
      #1;
      total++; if (m_ack !== 2'b01) $display("FAIL race_ack: got %b want 01", m_ack); else passed++;
      total++; if (m_err !== 2'b00) $display("FAIL race_err: got %b want 00", m_err); else passed++;
      total++; if (s_cyc !== 1'b1) $display("FAIL race_scyc: got %b want 1", s_cyc); else passed++;
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      total++; if (grant !== 2'b00) $display("FAIL race_idle: got %b want 00", grant); else passed++;
   endtask

   initial begin
      reset_n = 1'b0;
      m_cyc   = 2'b00;
      m_stb   = 2'b00;
      m_we    = 2'b00;
      m_addr  = '0;
      m_data  = '0;
      s_ack   = 1'b0;
      s_rdata = '0;
      test_reset();
      test_round_robin();
      test_burst_hold();
      test_write_mux();
      test_timeout();
      test_ack_vs_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
